// File: rtl/cache_types.sv
// Shared types and geometry for the 4-way, 8-set, 256-bit-line cache.
package cache_types;

  localparam int TAG_W    = 24;
  localparam int SET_W    = 3;
  localparam int LINE_W   = 256;
  localparam int WAYS     = 4;
  localparam int OFFSET_W = 32 - TAG_W - SET_W;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WRITEBACK,
    REFILL,
    INSTALL,
    DONE
  } miss_state_t;

  // Line-aligned DRAM address for a given tag and set.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [SET_W-1:0] set_idx);
    return {tag, set_idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Victim way choice: the lowest-index invalid way, else the 3-bit tree-PLRU way.
module plru_victim_sel
  import cache_types::*;
(
  input  logic [WAYS-1:0] valid,
  input  logic [2:0]      lru,
  output logic [1:0]      victim
);

  always_comb begin
    // NOTE: victim gets a value on every path before the loop can override it,
    // so no latch is inferred.
    victim = lru[0] ? {1'b1, lru[2]} : {1'b0, lru[1]};
    // Scan downwards so the lowest-index invalid way wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) victim = 2'(i);
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss handler: picks a victim, writes it back if dirty, refills over dfp,
// installs the new line and releases the pipeline stall.
module cache_miss_ctrl
  import cache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  input  logic [2:0]        lru_in,
  input  logic [WAYS-1:0]   valid_in,
  input  logic [WAYS-1:0]   dirty_in,
  input  logic [TAG_W-1:0]  tag_in [WAYS],
  input  logic [LINE_W-1:0] data_in [WAYS],
  input  logic              dfp_resp,
  input  logic [LINE_W-1:0] dfp_rdata,
  output logic [31:0]       dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  output logic [WAYS-1:0]   arr_web,
  output logic [SET_W-1:0]  arr_set,
  output logic [TAG_W-1:0]  arr_tag,
  output logic [LINE_W-1:0] arr_wdata,
  output logic              arr_valid,
  output logic              arr_dirty,
  output logic              halt,
  output logic              miss_done
);

  miss_state_t       state;
  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic [1:0]        victim_q;
  logic [LINE_W-1:0] line_q;
  logic [1:0]        victim;
  logic              unused_offset;

  // The byte offset of the missing access never matters for a line refill.
  assign unused_offset = ^miss_addr[OFFSET_W-1:0];

  plru_victim_sel u_victim (
    .valid  (valid_in),
    .lru    (lru_in),
    .victim (victim)
  );

  // The line buffer feeds both the writeback data and the install data.
  assign dfp_wdata = line_q;
  assign arr_wdata = line_q;
  assign arr_set   = set_q;
  assign arr_tag   = tag_q;
  assign arr_dirty = 1'b0;

  // Outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every branch sees the
    // pre-edge values of the state and registers.
    if (rst) begin
      state     <= IDLE;
      tag_q     <= '0;
      set_q     <= '0;
      victim_q  <= '0;
      line_q    <= '0;
      dfp_addr  <= '0;
      dfp_read  <= 1'b0;
      dfp_write <= 1'b0;
      arr_web   <= '1;
      arr_valid <= 1'b0;
      halt      <= 1'b0;
      miss_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            tag_q <= miss_addr[31:32-TAG_W];
            set_q <= miss_addr[OFFSET_W+SET_W-1:OFFSET_W];
            halt  <= 1'b1;
            state <= SELECT;
          end
        end

        SELECT: begin
          victim_q <= victim;
          line_q   <= data_in[victim];
          if (valid_in[victim] && dirty_in[victim]) begin
            dfp_write <= 1'b1;
            dfp_addr  <= line_addr(tag_in[victim], set_q);
            state     <= WRITEBACK;
          end else begin
            dfp_read <= 1'b1;
            dfp_addr <= line_addr(tag_q, set_q);
            state    <= REFILL;
          end
        end

        WRITEBACK: begin
          if (dfp_resp) begin
            dfp_write <= 1'b0;
            dfp_read  <= 1'b1;
            dfp_addr  <= line_addr(tag_q, set_q);
            state     <= REFILL;
          end
        end

        REFILL: begin
          if (dfp_resp) begin
            line_q    <= dfp_rdata;
            dfp_read  <= 1'b0;
            arr_web   <= ~(4'b0001 << victim_q);
            arr_valid <= 1'b1;
            state     <= INSTALL;
          end
        end

        INSTALL: begin
          arr_web   <= '1;
          arr_valid <= 1'b0;
          halt      <= 1'b0;
          miss_done <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          miss_done <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
